// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MAX_XLEN = 128;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  // Most-negative two's-complement value for an xlen-bit operand.
  function automatic logic [MAX_XLEN-1:0] min_signed(input int unsigned xlen);
    return MAX_XLEN'(1) << (xlen - 1);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction at entry and conditional two's-complement
// negation of the raw 2*XLEN result in FIX.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              sign_a_en,
  input  logic              sign_b_en,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg_a,
  output logic              neg_b,
  input  logic [2*XLEN-1:0] fix_in,
  input  logic              fix_neg,
  output logic [2*XLEN-1:0] fix_out
);

  always_comb begin
    neg_a   = sign_a_en & a[XLEN-1];
    neg_b   = sign_b_en & b[XLEN-1];
    mag_a   = neg_a ? (~a + 1'b1) : a;
    mag_b   = neg_b ? (~b + 1'b1) : b;
    fix_out = fix_neg ? (~fix_in + 1'b1) : fix_in;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one 2*XLEN register; stalls the upstream pipeline while busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [REG_W-1:0] rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [REG_W-1:0] rd_out
);

  localparam int unsigned     CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = XLEN'(min_signed(XLEN));

  state_e             state, state_nxt;
  op_e                op_c, op_q;
  logic [2*XLEN-1:0]  acc;
  logic [XLEN-1:0]    opnd;
  logic [CW-1:0]      cnt;
  logic               neg_q, fast_q, is_div_q;
  logic [XLEN-1:0]    result_q;
  logic [REG_W-1:0]   rd_q;

  logic               accept, is_div, sign_a_en, sign_b_en;
  logic               div_zero, ovf, fast;
  logic [XLEN-1:0]    fast_val;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               neg_a, neg_b;
  logic [2*XLEN-1:0]  fix_src, fix_out;
  logic [XLEN-1:0]    result_val;
  logic [XLEN:0]      mul_sum, div_diff;
  logic [2*XLEN-1:0]  mul_step, div_step;

  assign op_c      = op_e'(op);
  assign is_div    = op[2];
  assign sign_a_en = op_c inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sign_b_en = op_c inside {OP_MULH, OP_DIV, OP_REM};
  assign accept    = (state == S_IDLE) && start && !flush;

  // Signed DIV/REM are the even divide encodings (op[0] == 0).
  assign div_zero  = (rs2 == '0);
  assign ovf       = !op[0] && (rs1 == MIN_NEG) && (rs2 == '1);
  assign fast      = is_div && (div_zero || ovf);
  assign fast_val  = div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .a         (rs1),
    .b         (rs2),
    .sign_a_en (sign_a_en),
    .sign_b_en (sign_b_en),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .fix_in    (fix_src),
    .fix_neg   (neg_q),
    .fix_out   (fix_out)
  );

  // acc = {partial product, multiplier} for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step = {mul_sum, acc[XLEN-1:1]};
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    div_step = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    fix_src    = acc;
    result_val = fix_out[XLEN-1:0];
    if (fast_q) begin
      fix_src = {{XLEN{1'b0}}, acc[XLEN-1:0]};
    end else begin
      unique case (op_q)
        OP_DIV, OP_DIVU: fix_src = {{XLEN{1'b0}}, acc[XLEN-1:0]};
        OP_REM, OP_REMU: fix_src = {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]};
        OP_MULH, OP_MULHSU, OP_MULHU: result_val = fix_out[2*XLEN-1:XLEN];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = fast ? S_FIX : S_CALC;
      S_CALC: begin
        if (flush)            state_nxt = S_IDLE;
        else if (cnt == LAST) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_MUL;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      is_div_q <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      if (accept) begin
        op_q     <= op_c;
        rd_q     <= rd_in;
        cnt      <= '0;
        fast_q   <= fast;
        is_div_q <= is_div;
        if (fast) begin
          acc   <= {{XLEN{1'b0}}, fast_val};
          neg_q <= 1'b0;
        end else if (is_div) begin
          acc   <= {{XLEN{1'b0}}, mag_a};
          opnd  <= mag_b;
          neg_q <= op[1] ? neg_a : (neg_a ^ neg_b);
        end else begin
          acc   <= {{XLEN{1'b0}}, mag_b};
          opnd  <= mag_a;
          neg_q <= neg_a ^ neg_b;
        end
      end else if (state == S_CALC) begin
        cnt <= cnt + 1'b1;
        acc <= is_div_q ? div_step : mul_step;
      end
      if (done) result_q <= result_val;
    end
  end

  assign busy   = (state != S_IDLE);
  assign stall  = start | busy;
  assign done   = (state == S_FIX) && !flush;
  assign result = done ? result_val : result_q;
  assign rd_out = rd_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV64M multiply/divide unit for the execute stage of the pipelined RISC core. It accepts one M-extension operation at a time and computes it over multiple cycles with a radix-2 shift-add multiplier or a restoring divider. While it works, it holds the IF/ID/EX pipeline registers through `stall`. Operand width is parametrised, and divide-by-zero and signed-overflow take a 2-cycle fast path.

## Interface
- `XLEN`, 64: operand/result width; must be even and ≥ 8.
- `REG_W`, 5: destination register index width.

- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`, `rs2`  in  XLEN  operands, captured at accept.
- `rd_in`  in  REG_W  destination tag, captured at accept.
- `flush`  in  1  abort current operation (branch flush).
- `busy`  out  1  operation in flight.
- `stall`  out  1  `start | busy`; holds upstream pipeline registers.
- `done`  out  1  one-cycle result-valid pulse.
- `result`  out  XLEN  result; valid when `done`, otherwise holds its last value.
- `rd_out`  out  REG_W  captured tag, valid with `done`.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC on accept (`start` high in IDLE, `flush` low). Operands and tag are latched. Signed operands are converted to magnitudes and their sign flags stored. Iteration counter is cleared.
  - IDLE → FIX directly when the operation is divide-family and either `rs2`==0 or (signed DIV/REM with `rs1`=most-negative and `rs2`=−1).
  - CALC: one bit per cycle. Counter counts 0..XLEN−1; on the edge where the counter equals XLEN−1 → FIX.
  - FIX: apply sign correction and select the result. `done`=1 for exactly this cycle. → IDLE on the next edge.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the 2·XLEN product. The product is negated when the operand signs differ (MULHSU treats `rs2` as unsigned).
  - DIV/DIVU: quotient. REM/REMU: remainder. Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Fast-path results:
  - Divide by 0: DIV/DIVU give all-ones; REM/REMU give `rs1`.
  - Signed overflow: DIV gives `rs1`; REM gives 0.
- `start` while `busy`: ignored. The pipeline is already stalled, so upstream cannot legally issue.
- `flush`: in CALC or FIX, returns to IDLE on the next edge with no `done`. In IDLE, `flush` blocks acceptance that cycle.
- `start` in the same cycle as FIX→IDLE: not accepted. Acceptance happens in the following IDLE cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `rd_out` 0, counter 0. `stall` equals `start` during reset.
- Normal latency: with `start` high in cycle k (IDLE), `done` is high in cycle k+XLEN+1. `busy` is high for cycles k+1..k+XLEN+1. Back-to-back ops: next accept at the earliest in cycle k+XLEN+2.
- Fast-path latency: `done` is high in cycle k+1.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous); no `done`.
- `stall` is combinational from `start`. It covers the accept cycle, so the issuing instruction stays in EX until `done`.

## Structure
- `muldiv_pkg`: op enum (funct3 values), FSM state enum, and a helper function for the signed-overflow constant as a function of XLEN.
- One sub-module, `muldiv_sign_fix`: combinational operand-magnitude and result-negation logic, shared by entry and FIX.
- Datapath registers: 2·XLEN accumulator/remainder-quotient register, XLEN multiplicand/divisor register, counter of $clog2(XLEN)+1 bits.

## Test plan
- MUL 7 × −3 with `start` in cycle 0 → `result`=0xFFFF_FFFF_FFFF_FFEB, `done` only in cycle 65, `rd_out`=captured tag, `stall` high cycles 0–65.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → 1. MULH −1 × −1 → 0. MULHSU −1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD (−3). REM −7 / 2 → 0xFFFF_FFFF_FFFF_FFFF (−1). DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → all-ones and REM 5 / 0 → 5, each with `done` in cycle 1. DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000 and REM → 0, each in cycle 1.
- `flush` in cycle 10 of a DIV → `busy` low in cycle 11, no `done` ever. A new MUL 3 × 4 issued in cycle 12 → 12 in cycle 77.
- `rst` pulled low in cycle 20 of a MUL → all outputs 0 immediately. After release, `start` is accepted on the first IDLE cycle. `start` held high throughout a running op → exactly one `done`.
